// File: rtl/vcve2_pkg.sv
// ----------------------------------------------------------------------------
// vcve2_pkg
// Shared types and helpers for the vcve2 memory arbiter slice.
//   owner_e  : identifies which requester owns a memory transaction.
//   rr_pick  : round-robin winner when both requesters compete.
// ----------------------------------------------------------------------------
package vcve2_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // On a tie the requester that was not granted last wins.
    function automatic owner_e rr_pick(input owner_e last_grant);
        owner_e winner;
        if (last_grant == OWNER_DATA) begin
            winner = OWNER_INSTR;
        end else begin
            winner = OWNER_DATA;
        end
        return winner;
    endfunction

endpackage

// File: rtl/vcve2_arb_owner_fifo.sv
// ----------------------------------------------------------------------------
// vcve2_arb_owner_fifo
// Small in-order FIFO that records which requester owns each granted
// transaction still waiting for its response.
//   clk_i/rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/data_i: enqueue data_i (ignored when full)
//   pop_i        : dequeue head (ignored when empty)
//   full_o/empty_o/head_o/count_o : status and oldest entry
// ----------------------------------------------------------------------------
module vcve2_arb_owner_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [Width-1:0]           head_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrW'(Depth - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    assign full_o    = (cnt_q == CntW'(Depth));
    assign empty_o   = (cnt_q == CntW'(0));
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

endmodule

// File: rtl/vcve2_mem_arbiter_sva.sv
// ----------------------------------------------------------------------------
// vcve2_mem_arbiter_sva
// Protocol checker for vcve2_mem_arbiter (no functional outputs).
// Watches grants, the locked address phase, requester behaviour while
// locked, instruction alignment and responses arriving with no owner.
// A response with no owner is tolerated only when a reset has discarded
// outstanding transactions whose responses may still be in flight.
// ----------------------------------------------------------------------------
module vcve2_mem_arbiter_sva
    import vcve2_pkg::*;
#(
    parameter int unsigned CntW = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    input logic            instr_req_i,
    input logic            data_req_i,
    input logic            instr_gnt_i,
    input logic            data_gnt_i,
    input logic            mem_req_i,
    input logic [31:0]     mem_addr_i,
    input owner_e          sel_i,
    input logic            lock_i,
    input owner_e          lock_owner_i,
    input logic            mem_rvalid_i,
    input logic            fifo_empty_i,
    input logic [CntW-1:0] count_i
);

    logic [CntW-1:0] shadow_q;
    logic [3:0]      allow_q;

    // Remember how many responses a reset left orphaned.
    always_ff @(posedge clk_i) begin
        shadow_q <= count_i;
        if (!rst_ni) begin
            allow_q <= allow_q + 4'(shadow_q);
        end else if (mem_rvalid_i && fifo_empty_i && (allow_q != 4'd0)) begin
            allow_q <= allow_q - 4'd1;
        end else begin
            allow_q <= allow_q;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_gnt_i && data_gnt_i));

    a_addr_stable_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_i |-> (mem_addr_i == $past(mem_addr_i)));

    a_req_held_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_i |-> ((lock_owner_i == OWNER_INSTR) ? instr_req_i : data_req_i));

    a_instr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_i && (sel_i == OWNER_INSTR)) |-> (mem_addr_i[1:0] == 2'b00));

    a_no_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_rvalid_i && fifo_empty_i) |-> (allow_q != 4'd0));

endmodule

// File: rtl/vcve2_mem_arbiter.sv
// ----------------------------------------------------------------------------
// vcve2_mem_arbiter
// Arbitrates the fetch (instr_*) and load/store (data_*) requesters onto one
// pipelined memory port. Round-robin on ties, selection locked while a
// request waits for mem_gnt_i, responses returned in grant order via an
// owner FIFO, at most MaxOutstanding transactions in flight.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   instr_*             : fetch requester (read-only)
//   data_*              : load/store requester
//   mem_*               : shared memory port
//   busy_o              : transaction outstanding or request pending
// ----------------------------------------------------------------------------
module vcve2_mem_arbiter
    import vcve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    owner_e          sel_s, head_s;
    owner_e          last_q, last_d;
    owner_e          lock_owner_q, lock_owner_d;
    logic            lock_q, lock_d;
    logic            full_s, empty_s, grant_s, pop_s;
    logic [0:0]      head_raw_s;
    logic [CntW-1:0] count_s;

    // Owner selection: a stalled request keeps its owner until granted.
    always_comb begin
        sel_s = OWNER_INSTR;
        if (lock_q) begin
            sel_s = lock_owner_q;
        end else if (instr_req_i && data_req_i) begin
            sel_s = rr_pick(last_q);
        end else if (data_req_i) begin
            sel_s = OWNER_DATA;
        end else begin
            sel_s = OWNER_INSTR;
        end
    end

    // Full depends only on registered occupancy, so rvalid never reaches req.
    assign mem_req_o   = (instr_req_i | data_req_i) & ~full_s;
    assign grant_s     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = grant_s & (sel_s == OWNER_INSTR);
    assign data_gnt_o  = grant_s & (sel_s == OWNER_DATA);

    // Address-phase mux; fetches are always full-word reads.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = 32'h0000_0000;
        if (sel_s == OWNER_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_addr_o  = instr_addr_i;
        end
    end

    // Next-state for last-grant and lock.
    always_comb begin
        last_d       = last_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (grant_s) begin
            last_d = sel_s;
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d       = 1'b1;
            lock_owner_d = sel_s;
        end else begin
            lock_d = 1'b0;
        end
    end

    // Arbitration state registers; data counts as last grant so instr wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q       <= OWNER_DATA;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
        end else begin
            last_q       <= last_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    vcve2_arb_owner_fifo #(
        .Depth (MaxOutstanding),
        .Width (1)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant_s),
        .data_i  (sel_s),
        .pop_i   (pop_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .head_o  (head_raw_s),
        .count_o (count_s)
    );

    // Responses with no recorded owner are dropped.
    assign pop_s          = mem_rvalid_i & ~empty_s;
    assign head_s         = owner_e'(head_raw_s);
    assign instr_rvalid_o = pop_s & (head_s == OWNER_INSTR);
    assign data_rvalid_o  = pop_s & (head_s == OWNER_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;
    assign busy_o         = ~empty_s | mem_req_o;

    vcve2_mem_arbiter_sva #(
        .CntW (CntW)
    ) u_sva (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .instr_req_i  (instr_req_i),
        .data_req_i   (data_req_i),
        .instr_gnt_i  (instr_gnt_o),
        .data_gnt_i   (data_gnt_o),
        .mem_req_i    (mem_req_o),
        .mem_addr_i   (mem_addr_o),
        .sel_i        (sel_s),
        .lock_i       (lock_q),
        .lock_owner_i (lock_owner_q),
        .mem_rvalid_i (mem_rvalid_i),
        .fifo_empty_i (empty_s),
        .count_i      (count_s)
    );

endmodule

// File: tb/tb_vcve2_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vcve2_mem_arbiter
// Randomized and directed stimulus; a behavioural model predicts the
// address phase each cycle, expected responses are queued at grant time and
// a negedge monitor pops and compares them when the DUT returns rvalid.
// ----------------------------------------------------------------------------
module tb_vcve2_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_be_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    vcve2_mem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        owner;   // 0 = instr, 1 = data
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];     // scoreboard: expected responses in grant order
    logic [32:0] mem_q[$];     // memory side: responses still to be returned
    logic        glog[$];      // observed grant owners for order checks
    int          checks = 0;
    int          failures = 0;

    // Reference model state
    int   m_out;
    logic m_last, m_lock, m_lock_owner;
    // Expectations for the current cycle
    logic        e_req, e_sel, e_grant, e_rv, e_busy, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        mon_en = 1'b0;
    logic        log_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: address-phase checks plus scoreboard pop on any response.
    always @(negedge clk_i) begin
        rsp_t r;
        if (rst_ni && mon_en) begin
            chk("mem_req", {31'd0, mem_req_o}, {31'd0, e_req});
            chk("instr_gnt", {31'd0, instr_gnt_o}, {31'd0, e_grant && !e_sel});
            chk("data_gnt", {31'd0, data_gnt_o}, {31'd0, e_grant && e_sel});
            chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
            if (e_req) begin
                chk("mem_addr", mem_addr_o, e_addr);
                chk("mem_we", {31'd0, mem_we_o}, {31'd0, e_we});
                chk("mem_be", {28'd0, mem_be_o}, {28'd0, e_be});
                chk("mem_wdata", mem_wdata_o, e_wd);
            end
            if (log_en && (instr_gnt_o || data_gnt_o)) glog.push_back(data_gnt_o);
            chk("rvalid_any", {31'd0, instr_rvalid_o | data_rvalid_o}, {31'd0, e_rv});
            if (instr_rvalid_o || data_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rvalid expected none queued");
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, !r.owner});
                    chk("rsp_data_rvalid", {31'd0, data_rvalid_o}, {31'd0, r.owner});
                    chk("rsp_rdata", r.owner ? data_rdata_o : instr_rdata_o, r.data);
                    chk("rsp_err", {30'd0, instr_err_o, data_err_o},
                        {30'd0, r.err && !r.owner, r.err && r.owner});
                end
            end else begin
                chk("err_idle", {30'd0, instr_err_o, data_err_o}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        mon_en = 1'b0;
        {instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i, mem_err_i} = 6'd0;
        instr_addr_i = 32'd0; data_addr_i = 32'd0; data_be_i = 4'd0;
        data_wdata_i = 32'd0; mem_rdata_i = 32'd0;
        exp_q.delete(); mem_q.delete();
        m_out = 0; m_last = 1'b1; m_lock = 1'b0; m_lock_owner = 1'b0;
        #2;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        chk("rst_rvalids", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
        chk("rst_errs", {30'd0, instr_err_o, data_err_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        {e_req, e_grant, e_rv, e_busy} = 4'd0;
        mon_en = 1'b1;
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da, input logic dwe,
                         input logic [3:0] dbe, input logic [31:0] dwd,
                         input logic g, input logic rv,
                         input logic [31:0] rsp_data, input logic rsp_err);
        instr_req_i = ir; instr_addr_i = ia;
        data_req_i = dr; data_addr_i = da; data_we_i = dwe;
        data_be_i = dbe; data_wdata_i = dwd;
        mem_gnt_i = g; mem_rvalid_i = rv;
        e_rv = rv && (m_out > 0);
        if (e_rv) {mem_rdata_i, mem_err_i} = mem_q.pop_front();
        else {mem_rdata_i, mem_err_i} = {$urandom, 1'b1};
        e_req = (ir || dr) && (m_out < MAXO);
        if (m_lock) e_sel = m_lock_owner;
        else if (ir && dr) e_sel = !m_last;
        else e_sel = dr;
        e_grant = e_req && g;
        e_busy = (m_out > 0) || e_req;
        e_addr = e_sel ? da : ia;
        e_we = e_sel ? dwe : 1'b0;
        e_be = e_sel ? dbe : 4'hF;
        e_wd = e_sel ? dwd : 32'd0;
        if (e_grant) begin
            exp_q.push_back({e_sel, rsp_data, rsp_err});
            mem_q.push_back({rsp_data, rsp_err});
        end
        @(posedge clk_i);
        m_out = m_out + int'(e_grant) - int'(e_rv);
        if (e_grant) m_last = e_sel;
        m_lock = e_req && !g;
        m_lock_owner = e_sel;
        #1;
    endtask

    task automatic idle(input logic rv);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, rv, 32'd0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_out > 0 && guard < 50) begin
            idle(1'b1);
            guard++;
        end
        chk("drain_scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic        ip, dp, dwe;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        logic        exp_order[$];

        do_reset();

        // Single fetch: grant, response two cycles later with 0x13.
        cycle(1'b1, 32'h80, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 32'h13, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Both requesting with gnt every cycle: strict alternation from instr.
        do_reset();
        glog.delete(); log_en = 1'b1;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i * 4), 1'b1, 4'h3,
                  32'hA0 + 32'(i), 1'b1, 1'b1, $urandom, 1'b0);
        log_en = 1'b0;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        chk("rr_order_len", glog.size(), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("rr_order", {31'd0, glog[i]}, {31'd0, exp_order[i]});
        drain();

        // Stalled data request keeps its address; instr follows.
        glog.delete(); log_en = 1'b1;
        cycle(1'b0, 32'h200, 1'b1, 32'h1000, 1'b0, 4'hF, 32'd0, 1'b0, 1'b0, 32'h5, 1'b0);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 32'h200, 1'b1, 32'h1000, 1'b0, 4'hF, 32'd0, 1'b0, 1'b0, 32'h5, 1'b0);
        cycle(1'b1, 32'h200, 1'b1, 32'h1000, 1'b0, 4'hF, 32'd0, 1'b1, 1'b0, 32'h5, 1'b0);
        cycle(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 4'h0, 32'd0, 1'b1, 1'b0, 32'h6, 1'b0);
        log_en = 1'b0;
        exp_order = '{1'b1, 1'b0};
        chk("lock_order_len", glog.size(), 32'd2);
        for (int i = 0; i < 2 && i < glog.size(); i++)
            chk("lock_order", {31'd0, glog[i]}, {31'd0, exp_order[i]});
        drain();

        // Fill to the limit, error response frees a slot the next cycle.
        cycle(1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 32'hE1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 4'hF, 32'd0, 1'b1, 1'b0, 32'hE2, 1'b0);
        cycle(1'b1, 32'h304, 1'b1, 32'h404, 1'b1, 4'h1, 32'h77, 1'b1, 1'b0, 32'hE3, 1'b0);
        cycle(1'b1, 32'h304, 1'b1, 32'h404, 1'b1, 4'h1, 32'h77, 1'b1, 1'b1, 32'hE3, 1'b0);
        cycle(1'b1, 32'h304, 1'b1, 32'h404, 1'b1, 4'h1, 32'h77, 1'b1, 1'b0, 32'hE4, 1'b0);
        drain();

        // Grant and response together, then reset with two outstanding.
        cycle(1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 32'hC1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'hC2, 1'b0);
        cycle(1'b1, 32'h504, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 32'hC3, 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic; requesters hold until granted.
        ip = 1'b0; dp = 1'b0; ia = 32'd0; da = 32'd0; dwe = 1'b0; dbe = 4'd0; dwd = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1; da = $urandom; dwe = ($urandom_range(0, 1) == 1);
                dbe = 4'($urandom); dwd = $urandom;
            end
            cycle(ip, ia, dp, da, dwe, dbe, dwd, ($urandom_range(0, 3) != 0),
                  (m_out > 0) && ($urandom_range(0, 2) != 0), $urandom,
                  ($urandom_range(0, 3) == 0));
            if (e_grant) begin
                if (e_sel) dp = 1'b0;
                else ip = 1'b0;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vcve2_mem_arbiter.md
VCVE2_MEM_ARBITER -- requirements
Module: vcve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, legal range 1..4: maximum number of granted transactions awaiting rvalid.
REQ-002 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have ports instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1: fetch requester (prefetch buffer side), read-only.
REQ-005 SHALL have ports data_req_i in 1, data_addr_i in 32, data_we_i in 1, data_be_i in 4, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1: load/store/vector requester.
REQ-006 SHALL have ports mem_req_o out 1, mem_addr_o out 32, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1: shared memory port.
REQ-007 SHALL have port busy_o, out, 1: high while any transaction is outstanding or mem_req_o is high.

Function
REQ-008 Address phase: mem_req_o = (instr_req_i | data_req_i) & ~full, where full = (outstanding count == MaxOutstanding).
REQ-009 Selection when unlocked: only one requester -> that one; both -> the one not granted last (round-robin, 1-bit last-grant register).
REQ-010 Lock: if mem_req_o=1 and mem_gnt_i=0, the selection SHALL be registered and held until the cycle mem_gnt_i=1; the other requester SHALL NOT be selected meanwhile.
REQ-011 mem_addr_o/we/be/wdata SHALL mux from the selected requester; instruction selection drives we=0, be=4'hF, wdata=0.
REQ-012 instr_gnt_o = mem_req_o & mem_gnt_i & sel==instr; data_gnt_o likewise for data; never both high.
REQ-013 On a grant, the last-grant register SHALL update to the granted owner and its owner ID SHALL be pushed into the owner FIFO (depth MaxOutstanding).
REQ-014 Response phase: on mem_rvalid_i, the FIFO head SHALL be popped; the owner's rvalid_o = 1 the same cycle (zero latency, combinational); the other's rvalid_o = 0.
REQ-015 instr_rdata_o and data_rdata_o SHALL both carry mem_rdata_i; err_o SHALL be mem_err_i gated by that owner's rvalid.
REQ-016 Responses SHALL be returned in grant order; no reordering.
REQ-017 Simultaneous grant and rvalid: push and pop the same cycle; count unchanged; FIFO order preserved.
REQ-018 Full: mem_req_o held low even if mem_rvalid_i is high that cycle (no rvalid->req combinational path); request resumes the next cycle.
REQ-019 mem_rvalid_i with empty FIFO SHALL be dropped (no rvalid_o), count stays 0; flagged by assertion.
REQ-020 Requester deasserting req_i before grant while unlocked: selection re-evaluated freely; while locked, deassertion is a protocol violation (assertion).
REQ-021 Count arithmetic: width $clog2(MaxOutstanding+1); no wrap; overflow/underflow impossible by REQ-018/019.

Reset
REQ-022 Upon rst_ni low: FIFO empty, count 0, lock cleared, last-grant = data (instr wins first tie).
REQ-023 Reset outputs: mem_req_o, all gnt_o, all rvalid_o, err_o, busy_o = 0 while no requester is active.
REQ-024 Reset mid-transaction SHALL discard outstanding ownership; later stray rvalid follows REQ-019.

Structure
REQ-025 Typedef owner_e {OWNER_INSTR=1'b0, OWNER_DATA=1'b1} SHALL live in vcve2_pkg.
REQ-026 Owner FIFO SHALL be sub-module vcve2_arb_owner_fifo (params Depth, Width; push/pop/full/empty/head).
REQ-027 Assertions: gnt one-hot0, address stable while locked, no rvalid when empty, mem_addr_o[1:0]==0 for instr.

Verification
REQ-028 instr_req_i=1 addr 0x80, gnt same cycle, rvalid 2 cycles later rdata 0x00000013 -> instr_gnt_o pulse, instr_rvalid_o=1 with rdata 0x13, data_rvalid_o=0.
REQ-029 Both req held 4 cycles, gnt every cycle -> grant order instr,data,instr,data; FIFO contents match.
REQ-030 data_req_i addr 0x1000, mem_gnt_i low 3 cycles, instr_req_i rising cycle 1 -> mem_addr_o stays 0x1000 until gnt; instr granted next.
REQ-031 MaxOutstanding=2, two grants, no rvalid -> mem_req_o=0 while req high; rvalid with err=1 -> first owner gets err_o=1, mem_req_o returns next cycle.
REQ-032 Grant and rvalid same cycle with count=1 -> count stays 1, response to oldest owner; rst_ni low with count=2 -> count 0, busy_o=0, subsequent rvalid dropped.
